// File: rtl/proc_multicycle_param.sv
// proc_multicycle_param: parametrised multicycle processor.
//
// Each instruction is accepted in T0 and executed over one (mv, mvi, mvnz, nop) or three
// (add, sub, and, xor) further steps. All register transfers go over a single shared bus.
// Instruction word layout: op = din[IW-1:IW-3], rx = din[2*RW-1:RW], ry = din[RW-1:0].
//
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous active-low reset
//   run       start request, sampled only in T0
//   din       instruction word (T0) or immediate (mvi, T1)
//   buswires  shared bus value (combinational, 0 when idle)
//   done      high during the final step of an instruction
//   busy      high whenever the machine is not in T0
//   zflag     registered zero flag of the last ALU result
module proc_multicycle_param #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned RW   = $clog2(NREG),
    parameter int unsigned IW   = 3 + 2 * RW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          run,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] buswires,
    output logic          done,
    output logic          busy,
    output logic          zflag
);

    typedef enum logic [1:0] {
        StT0 = 2'd0,
        StT1 = 2'd1,
        StT2 = 2'd2,
        StT3 = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OpMv   = 3'b000,
        OpMvi  = 3'b001,
        OpAdd  = 3'b010,
        OpSub  = 3'b011,
        OpAnd  = 3'b100,
        OpMvnz = 3'b101,
        OpXor  = 3'b110,
        OpNop  = 3'b111
    } op_e;

    localparam logic [DW-1:0] One = DW'(1);

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] a_q;
    logic [DW-1:0] g_q;
    logic          zflag_q;

    op_e           op;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic          is_alu;
    logic [DW-1:0] alu_res;

    logic          done_raw;
    logic          ir_we;
    logic          reg_we;
    logic          a_we;
    logic          g_we;
    logic          z_we;

    assign op     = op_e'(ir_q[IW-1:IW-3]);
    assign rx     = ir_q[2*RW-1:RW];
    assign ry     = ir_q[RW-1:0];
    assign is_alu = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpXor);

    // ALU operates on A and whatever is on the bus in T2 (R[ry]).
    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd:   alu_res = a_q + buswires;
            OpSub:   alu_res = a_q + ~buswires + One;
            OpAnd:   alu_res = a_q & buswires;
            OpXor:   alu_res = a_q ^ buswires;
            default: alu_res = '0;
        endcase
    end

    // Next-state and bus/control decode.
    always_comb begin
        state_d  = state_q;
        buswires = '0;
        done_raw = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        a_we     = 1'b0;
        g_we     = 1'b0;
        z_we     = 1'b0;
        case (state_q)
            StT0: begin
                if (run) begin
                    ir_we   = 1'b1;
                    state_d = StT1;
                end
            end
            StT1: begin
                case (op)
                    OpMv: begin
                        buswires = regs_q[ry];
                        reg_we   = 1'b1;
                        done_raw = 1'b1;
                        state_d  = StT0;
                    end
                    OpMvi: begin
                        buswires = din;
                        reg_we   = 1'b1;
                        done_raw = 1'b1;
                        state_d  = StT0;
                    end
                    OpAdd, OpSub, OpAnd, OpXor: begin
                        buswires = regs_q[rx];
                        a_we     = 1'b1;
                        state_d  = StT2;
                    end
                    OpMvnz: begin
                        buswires = regs_q[ry];
                        reg_we   = ~zflag_q;
                        done_raw = 1'b1;
                        state_d  = StT0;
                    end
                    default: begin
                        done_raw = 1'b1;
                        state_d  = StT0;
                    end
                endcase
            end
            StT2: begin
                state_d = StT0;
                if (is_alu) begin
                    buswires = regs_q[ry];
                    g_we     = 1'b1;
                    state_d  = StT3;
                end
            end
            StT3: begin
                state_d = StT0;
                if (is_alu) begin
                    buswires = g_q;
                    reg_we   = 1'b1;
                    z_we     = 1'b1;
                    done_raw = 1'b1;
                end
            end
            default: state_d = StT0;
        endcase
    end

    // Every register write takes its data from the bus (R[ry], din or G).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StT0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            zflag_q <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                ir_q <= din[IW-1:0];
            end
            if (a_we) begin
                a_q <= buswires;
            end
            if (g_we) begin
                g_q <= alu_res;
            end
            if (z_we) begin
                zflag_q <= (g_q == '0);
            end
            if (reg_we) begin
                regs_q[rx] <= buswires;
            end
        end
    end

    assign done  = done_raw & resetn;
    assign busy  = (state_q != StT0);
    assign zflag = zflag_q;

endmodule

// File: tb/tb_proc_multicycle_param.sv
// Testbench for proc_multicycle_param: a 16-bit/8-register instance driven with directed and
// random instructions against an instruction-level reference model, plus a small 8-bit/4-register
// instance exercising carry wrap.
module tb_proc_multicycle_param;

    logic        clk = 1'b0;
    logic        resetn, run;
    logic [15:0] din, bus;
    logic        done, busy, zflag;

    logic        resetn8, run8;
    logic [7:0]  din8, bus8;
    logic        done8, busy8, zflag8;

    int checks = 0;
    int failures = 0;

    // Reference model state: architectural registers and zero flag.
    logic [15:0] mreg [8];
    logic        mz;

    always #5 clk = ~clk;

    proc_multicycle_param #(.DW(16), .NREG(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .run      (run),
        .din      (din),
        .buswires (bus),
        .done     (done),
        .busy     (busy),
        .zflag    (zflag)
    );

    proc_multicycle_param #(.DW(8), .NREG(4)) dut8 (
        .clk      (clk),
        .resetn   (resetn8),
        .run      (run8),
        .din      (din8),
        .buswires (bus8),
        .done     (done8),
        .busy     (busy8),
        .zflag    (zflag8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] eb, input logic ed,
                              input logic ebusy);
        check({tag, ".bus"}, 32'(bus), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
        check({tag, ".busy"}, 32'(busy), 32'(ebusy));
        check({tag, ".zflag"}, 32'(zflag), 32'(mz));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        mz = 1'b0;
    endtask

    // Reset asserted during the current step: done must drop, then the machine is idle and clear.
    task automatic do_abort(input string tag, input logic [15:0] eb);
        resetn = 1'b0;
        #1;
        check_outs(tag, eb, 1'b0, 1'b1);
        @(posedge clk);
        model_clear();
        #1;
        resetn = 1'b1;
        run    = 1'b0;
        #1;
        check_outs({tag, "_after"}, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        run = 1'b0;
        din = 16'($urandom);
        #1;
        check_outs("idle", 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; called and returns just after a clock edge with the DUT in T0.
    task automatic exec(input logic [2:0] op, input int rx, input int ry, input logic [15:0] imm,
                        input bit drop_run, input int abort_at);
        logic [2:0]  rxb, ryb;
        logic [15:0] a, b, g, eb;
        rxb    = 3'(rx);
        ryb    = 3'(ry);
        resetn = 1'b1;
        run    = 1'b1;
        din    = {7'd0, op, rxb, ryb};
        #1;
        check_outs("t0", 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        run = drop_run ? 1'b0 : 1'($urandom);
        din = (op == 3'b001) ? imm : 16'($urandom);
        #1;
        if (op inside {3'd2, 3'd3, 3'd4, 3'd6}) begin
            a = mreg[rxb];
            check_outs("alu_t1", a, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            run = drop_run ? 1'b0 : 1'($urandom);
            din = 16'($urandom);
            #1;
            b = mreg[ryb];
            case (op)
                3'd2:    g = a + b;
                3'd3:    g = a - b;
                3'd4:    g = a & b;
                default: g = a ^ b;
            endcase
            if (abort_at == 2) begin
                do_abort("abort_t2", b);
                return;
            end
            check_outs("alu_t2", b, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            run = drop_run ? 1'b0 : 1'($urandom);
            #1;
            if (abort_at == 3) begin
                do_abort("abort_t3", g);
                return;
            end
            check_outs("alu_t3", g, 1'b1, 1'b1);
            @(posedge clk);
            mreg[rxb] = g;
            mz        = (g == 16'h0);
        end else begin
            case (op)
                3'd0:    eb = mreg[ryb];
                3'd1:    eb = imm;
                3'd5:    eb = mreg[ryb];
                default: eb = 16'h0;
            endcase
            check_outs("short_t1", eb, 1'b1, 1'b1);
            @(posedge clk);
            if (op == 3'd0 || op == 3'd1 || (op == 3'd5 && !mz)) mreg[rxb] = eb;
        end
        #1;
    endtask

    // mv r,r puts every register on the bus so the whole file is compared with the model.
    task automatic dump();
        for (int r = 0; r < 8; r++) exec(3'd0, r, r, 16'h0, 1'b0, 0);
    endtask

    initial begin
        resetn  = 1'b0;
        run     = 1'b0;
        din     = 16'h0;
        resetn8 = 1'b0;
        run8    = 1'b0;
        din8    = 8'h0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 16'h0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // mvi / mv / add
        exec(3'd1, 0, 0, 16'h1234, 1'b0, 0);
        exec(3'd0, 1, 0, 16'h0, 1'b0, 0);
        exec(3'd2, 0, 1, 16'h0, 1'b0, 0);
        // sub to zero, mvnz blocked, wrap-around sub, mvnz taken
        exec(3'd3, 1, 1, 16'h0, 1'b0, 0);
        exec(3'd5, 2, 0, 16'h0, 1'b0, 0);
        exec(3'd1, 3, 0, 16'h0, 1'b0, 0);
        exec(3'd3, 3, 0, 16'h0, 1'b0, 0);
        exec(3'd5, 2, 0, 16'h0, 1'b0, 0);
        dump();
        // run dropped mid-instruction, then reset in T2 and in T3
        exec(3'd2, 0, 1, 16'h0, 1'b1, 0);
        exec(3'd2, 0, 1, 16'h0, 1'b0, 2);
        dump();
        exec(3'd1, 5, 0, 16'h00AA, 1'b0, 0);
        exec(3'd6, 5, 5, 16'h0, 1'b0, 3);
        dump();
        // and / xor / nop
        exec(3'd1, 0, 0, 16'h0F0F, 1'b0, 0);
        exec(3'd1, 1, 0, 16'h00FF, 1'b0, 0);
        exec(3'd4, 0, 1, 16'h0, 1'b0, 0);
        exec(3'd6, 0, 0, 16'h0, 1'b0, 0);
        exec(3'd7, 2, 3, 16'h0, 1'b0, 0);
        dump();

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [2:0] rop;
            rop = 3'($urandom);
            if ($urandom_range(0, 7) == 0) idle();
            exec(rop, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 16'($urandom), 1'($urandom), 0);
        end
        dump();

        // 8-bit, 4-register instance: mvi r3,#0xFF then add r3,r3 drops the carry.
        resetn8 = 1'b1;
        run8    = 1'b1;
        din8    = 8'h1C;
        #1;
        check("w8_t0.bus", 32'(bus8), 32'h0);
        check("w8_t0.busy", 32'(busy8), 32'h0);
        @(posedge clk);
        #1;
        din8 = 8'hFF;
        run8 = 1'b0;
        #1;
        check("w8_mvi.bus", 32'(bus8), 32'hFF);
        check("w8_mvi.done", 32'(done8), 32'h1);
        @(posedge clk);
        #1;
        din8 = 8'h2F;
        run8 = 1'b1;
        #1;
        check("w8_t0b.busy", 32'(busy8), 32'h0);
        @(posedge clk);
        #1;
        run8 = 1'b0;
        #1;
        check("w8_add_t1.bus", 32'(bus8), 32'hFF);
        check("w8_add_t1.done", 32'(done8), 32'h0);
        @(posedge clk);
        #2;
        check("w8_add_t2.bus", 32'(bus8), 32'hFF);
        @(posedge clk);
        #2;
        check("w8_add_t3.bus", 32'(bus8), 32'hFE);
        check("w8_add_t3.done", 32'(done8), 32'h1);
        @(posedge clk);
        #2;
        check("w8_end.busy", 32'(busy8), 32'h0);
        check("w8_end.zflag", 32'(zflag8), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
